// File: rtl/warp_ahbs_sram_pkg.sv
// Shared AHB encodings, FSM state type and lane/alignment helpers for the SRAM subordinate.
package warp_ahbs_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef enum logic [1:0] {
    AHB_HTRANS_IDLE   = 2'b00,
    AHB_HTRANS_BUSY   = 2'b01,
    AHB_HTRANS_NONSEQ = 2'b10,
    AHB_HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    AHB_HSIZE_BYTE  = 3'd0,
    AHB_HSIZE_HALF  = 3'd1,
    AHB_HSIZE_WORD  = 3'd2,
    AHB_HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    AHB_HRESP_OKAY  = 1'b0,
    AHB_HRESP_ERROR = 1'b1
  } hresp_e;

  // Byte lanes touched by a transfer of the given size at the given offset in the dword.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      AHB_HSIZE_BYTE: m = 8'h01;
      AHB_HSIZE_HALF: m = 8'h03;
      AHB_HSIZE_WORD: m = 8'h0F;
      default:        m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Natural alignment check; sizes above a dword are never aligned.
  function automatic logic aligned(input logic [2:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      AHB_HSIZE_BYTE:  ok = 1'b1;
      AHB_HSIZE_HALF:  ok = (off[0] == 1'b0);
      AHB_HSIZE_WORD:  ok = (off[1:0] == 2'b00);
      AHB_HSIZE_DWORD: ok = (off == 3'b000);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/warp_ahbs_mem.sv
// Word-organised storage: one byte-enabled synchronous write port, one asynchronous read port.
module warp_ahbs_mem #(
  parameter int DEPTH     = 256,
  parameter int NUM_LANES = 8,
  parameter int IDXW      = 8
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [IDXW-1:0]           idx_i,
  input  logic [NUM_LANES-1:0]      be_i,
  input  logic [NUM_LANES-1:0][7:0] wdata_i,
  output logic [NUM_LANES-1:0][7:0] rdata_o
);

  logic [NUM_LANES-1:0][7:0] mem_q [DEPTH];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be_i[l]) mem_q[idx_i][l] <= wdata_i[l];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/warp_ahbs_sram.sv
// AHB subordinate fronting a 64-bit SRAM: optional wait states, two-cycle ERROR on illegal transfers.
module warp_ahbs_sram
  import warp_ahbs_sram_pkg::*;
#(
  parameter int addr_width  = 32,
  parameter int data_width  = 64,
  parameter int depth       = 256,
  parameter int wait_states = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ahb_hsel,
  input  logic [addr_width-1:0]   i_ahb_haddr,
  input  logic [1:0]              i_ahb_htrans,
  input  logic                    i_ahb_hwrite,
  input  logic [2:0]              i_ahb_hsize,
  input  logic [data_width-1:0]   i_ahb_hwdata,
  input  logic [data_width/8-1:0] i_ahb_hwstrb,
  input  logic                    i_ahb_hready,
  output logic [data_width-1:0]   o_ahb_hrdata,
  output logic                    o_ahb_hreadyout,
  output logic                    o_ahb_hresp
);

  localparam int NUM_LANES = data_width / 8;
  localparam int IDXW      = (depth > 1) ? $clog2(depth) : 1;
  localparam int LOW       = IDXW + 3;
  localparam logic [addr_width:0] LIMIT = (addr_width + 1)'(depth * 8);

  state_e         state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           dphase_q, dphase_d;   // an OKAY data phase is in flight
  logic [LOW-1:0] addr_q, addr_d;       // only the bits that select word and lane
  logic           write_q, write_d;
  logic [2:0]     size_q, size_d;

  logic accept, legal, done;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] rdata;

  assign accept = i_ahb_hsel && i_ahb_hready &&
                  (i_ahb_htrans == AHB_HTRANS_NONSEQ || i_ahb_htrans == AHB_HTRANS_SEQ);
  assign legal  = ({1'b0, i_ahb_haddr} < LIMIT) && aligned(i_ahb_hsize, i_ahb_haddr[2:0]);

  // Completing cycle of an OKAY data phase: write commits on its closing edge, read data shown.
  assign done = (state_q == ST_IDLE) && dphase_q;
  assign be   = lane_mask(size_q, addr_q[2:0]) & i_ahb_hwstrb;

  // State and registered address-phase fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      dphase_q <= dphase_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
    end
  end

  // Next state and bus handshake; new address phases are only taken while ready is high.
  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    dphase_d        = dphase_q;
    addr_d          = addr_q;
    write_d         = write_q;
    size_d          = size_q;
    o_ahb_hreadyout = 1'b1;
    o_ahb_hresp     = AHB_HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        o_ahb_hreadyout = 1'b0;
        wcnt_d          = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = ST_IDLE;
      end
      ST_ERR1: begin
        o_ahb_hreadyout = 1'b0;
        o_ahb_hresp     = AHB_HRESP_ERROR;
        state_d         = ST_ERR2;
      end
      default: begin
        if (state_q == ST_ERR2) o_ahb_hresp = AHB_HRESP_ERROR;
        state_d  = ST_IDLE;
        dphase_d = 1'b0;
        if (accept) begin
          addr_d  = i_ahb_haddr[LOW-1:0];
          write_d = i_ahb_hwrite;
          size_d  = i_ahb_hsize;
          if (!legal) begin
            state_d = ST_ERR1;
          end else begin
            dphase_d = 1'b1;
            if (wait_states != 0) begin
              state_d = ST_WAIT;
              wcnt_d  = 4'(wait_states);
            end
          end
        end
      end
    endcase
  end

  assign o_ahb_hrdata = (done && !write_q) ? rdata : '0;

  warp_ahbs_mem #(
    .DEPTH    (depth),
    .NUM_LANES(NUM_LANES),
    .IDXW     (IDXW)
  ) u_mem (
    .clk_i  (i_clk),
    .we_i   (done && write_q),
    .idx_i  (addr_q[LOW-1:3]),
    .be_i   (be),
    .wdata_i(i_ahb_hwdata),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_warp_ahbs_sram.sv
// Scoreboard bench: driver pushes expected responses from a byte-level memory model, monitor pops on completion.
module tb_warp_ahbs_sram;

  localparam int DEPTH = 256;
  localparam int WS2   = 2;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } xfer_t;

  typedef struct {
    bit          err;
    int          nwait;
    logic [63:0] data;
    logic [63:0] mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cur;      // 0: zero-wait instance, 1: two-wait instance
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic [63:0] rd0, rd2, hrdata;
  logic        ro0, ro2, rs0, rs2, hreadyout, hresp;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  xfer_t xq[$];
  exp_t  expq[$];
  logic [63:0] mdl   [2][DEPTH];
  logic [7:0]  known [2][DEPTH];

  always #5 clk = ~clk;

  assign hreadyout = cur ? ro2 : ro0;
  assign hresp     = cur ? rs2 : rs0;
  assign hrdata    = cur ? rd2 : rd0;

  warp_ahbs_sram #(.wait_states(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ahb_hsel(hsel & ~cur), .i_ahb_haddr(haddr),
    .i_ahb_htrans(htrans), .i_ahb_hwrite(hwrite), .i_ahb_hsize(hsize),
    .i_ahb_hwdata(hwdata), .i_ahb_hwstrb(hwstrb), .i_ahb_hready(ro0),
    .o_ahb_hrdata(rd0), .o_ahb_hreadyout(ro0), .o_ahb_hresp(rs0));

  warp_ahbs_sram #(.wait_states(WS2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ahb_hsel(hsel & cur), .i_ahb_haddr(haddr),
    .i_ahb_htrans(htrans), .i_ahb_hwrite(hwrite), .i_ahb_hsize(hsize),
    .i_ahb_hwdata(hwdata), .i_ahb_hwstrb(hwstrb), .i_ahb_hready(ro2),
    .o_ahb_hrdata(rd2), .o_ahb_hreadyout(ro2), .o_ahb_hresp(rs2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: legality from address/size rules, byte-granular memory with known-byte tracking.
  task automatic push_expect(input xfer_t x);
    exp_t e;
    bit   legal;
    int   w, off, n;
    legal = (x.size <= 3) && (x.addr < 32'(DEPTH * 8));
    if (legal) legal = (x.addr % (32'd1 << x.size)) == 0;
    e.err   = !legal;
    e.nwait = legal ? (cur ? WS2 : 0) : 1;
    e.data  = '0;
    e.mask  = '1;
    if (legal) begin
      w   = int'(x.addr / 8);
      off = int'(x.addr % 8);
      n   = 1 << x.size;
      if (x.wr) begin
        for (int b = 0; b < 8; b++) begin
          if (b >= off && b < off + n && x.strb[b]) begin
            mdl[cur][w][b*8 +: 8] = x.wdata[b*8 +: 8];
            known[cur][w][b] = 1'b1;
          end
        end
      end else begin
        e.data = mdl[cur][w];
        for (int b = 0; b < 8; b++) e.mask[b*8 +: 8] = {8{known[cur][w][b]}};
      end
    end
    expq.push_back(e);
  endtask

  task automatic q_x(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [63:0] d, input logic [7:0] s, input logic [1:0] tr);
    xfer_t x;
    x.sel = 1'b1; x.trans = tr; x.wr = wr; x.addr = a; x.size = sz; x.wdata = d; x.strb = s;
    xq.push_back(x);
  endtask

  function automatic xfer_t rnd_xfer();
    xfer_t x;
    int r, k;
    logic [31:0] a;
    r = $urandom_range(0, 99);
    x.sel   = (r >= 5);
    x.trans = (r < 15) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    x.wr    = 1'($urandom_range(0, 1));
    x.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    k = $urandom_range(0, 19);
    if (k == 0)      a = 32'h800 + 32'($urandom_range(0, 255));
    else if (k == 1) a = 32'h8000_0000 | 32'($urandom_range(0, 127));
    else if (k == 2) a = 32'h7F8 + 32'($urandom_range(0, 7));
    else             a = 32'($urandom_range(0, 127));
    if (x.size <= 3 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << x.size) - 32'd1);
    x.addr  = a;
    x.wdata = {$urandom, $urandom};
    x.strb  = 8'($urandom);
    return x;
  endfunction

  // Pipelined master: address of the next transfer overlaps the data phase of the current one.
  task automatic run_xfers();
    xfer_t x, dp;
    bit    have_dp, acc;
    int    guard;
    have_dp = 0;
    while (xq.size() > 0 || have_dp) begin
      acc = 0;
      if (xq.size() > 0) begin
        x = xq.pop_front();
        hsel = x.sel; haddr = x.addr; htrans = x.trans; hwrite = x.wr; hsize = x.size;
        acc = x.sel && x.trans[1];
        if (acc) push_expect(x);
      end else begin
        hsel = 0; htrans = 2'b00; haddr = $urandom; hwrite = 0; hsize = 0;
      end
      if (have_dp && dp.wr) begin
        hwdata = dp.wdata; hwstrb = dp.strb;
      end else begin
        hwdata = {$urandom, $urandom}; hwstrb = 8'($urandom);
      end
      guard = 0;
      @(negedge clk);
      while (!hreadyout && guard <= 40) begin
        guard++;
        @(negedge clk);
      end
      if (guard > 40) begin
        checks++; errors++;
        $display("FAIL ready_timeout: hreadyout low for %0d cycles, limit 40", guard);
      end
      @(posedge clk); #1;
      have_dp = acc;
      dp = x;
    end
  endtask

  // Monitor: tracks accepted address phases and scores each data phase when it completes.
  int   lows;
  bit   pend, lo_all, lo_any;
  exp_t me;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      pend = 0;
    end else begin
      if (pend) begin
        if (!hreadyout) begin
          lows++;
          lo_all &= hresp;
          lo_any |= hresp;
          if (lows > 40) begin
            checks++; errors++;
            $display("FAIL dphase_timeout: %0d low cycles", lows);
            pend = 0;
          end
        end else begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL exp_underflow: data phase with no expectation queued");
          end else begin
            me = expq.pop_front();
            chk("wait_cycles", 64'(lows), 64'(me.nwait));
            chk("hresp", {62'd0, hresp, me.err ? lo_all : lo_any}, me.err ? 64'd3 : 64'd0);
            chk("rdata", hrdata & me.mask, me.data & me.mask);
          end
          pend = 0;
        end
      end else begin
        chk("idle_rdy_resp", {62'd0, hreadyout, hresp}, 64'd2);
        chk("idle_rdata", hrdata, 64'd0);
      end
      if (hreadyout && hsel && htrans[1]) begin
        pend = 1; lows = 0; lo_all = 1; lo_any = 0;
      end
    end
  end

  time t0;
  initial begin
    rst_n = 0; cur = 0; hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0;
    hwdata = 0; hwstrb = 0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) known[d][w] = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_rdy0", 64'(ro0), 64'd1);  chk("rst_resp0", 64'(rs0), 64'd0);  chk("rst_rdata0", rd0, 64'd0);
    chk("rst_rdy2", 64'(ro2), 64'd1);  chk("rst_resp2", 64'(rs2), 64'd0);  chk("rst_rdata2", rd2, 64'd0);
    rst_n = 1; mon_en = 1;
    @(posedge clk); #1;

    // zero-wait instance: dword write/read, byte merge, errors, back-to-back
    q_x(1, 32'h10, 3'd3, 64'h1122334455667788, 8'hFF, 2'b10);
    q_x(0, 32'h10, 3'd3, 64'h0, 8'h00, 2'b10);
    q_x(1, 32'h13, 3'd0, 64'h00000000AB000000, 8'hFF, 2'b10);
    q_x(0, 32'h10, 3'd3, 64'h0, 8'h00, 2'b10);
    run_xfers();
    q_x(0, 32'h800, 3'd3, 64'h0, 8'h00, 2'b10);
    q_x(1, 32'h11, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10);
    q_x(1, 32'h10, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10);
    q_x(0, 32'h10, 3'd3, 64'h0, 8'h00, 2'b10);
    run_xfers();
    t0 = $time;
    for (int i = 0; i < 4; i++)
      q_x(1, 32'(i * 8), 3'd3, {$urandom, $urandom}, 8'hFF, (i == 0) ? 2'b10 : 2'b11);
    run_xfers();
    chk("b2b_cycles", 64'(($time - t0) / 10), 64'd5);
    for (int i = 0; i < 4; i++)
      q_x(0, 32'(i * 8), 3'd3, 64'h0, 8'h00, (i == 0) ? 2'b10 : 2'b11);
    run_xfers();
    for (int i = 0; i < 150; i++) xq.push_back(rnd_xfer());
    run_xfers();

    // two-wait instance
    cur = 1;
    @(posedge clk); #1;
    q_x(1, 32'h10, 3'd3, 64'h1122334455667788, 8'hFF, 2'b10);
    q_x(0, 32'h10, 3'd3, 64'h0, 8'h00, 2'b10);
    q_x(1, 32'h20, 3'd3, 64'h0F0E0D0C0B0A0908, 8'hFF, 2'b10);
    run_xfers();

    // reset in the middle of a waited write: transfer must be dropped
    mon_en = 0;
    hsel = 1; haddr = 32'h20; htrans = 2'b10; hwrite = 1; hsize = 3'd3;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hwdata = 64'hDEADBEEF0BADF00D; hwstrb = 8'hFF;
    chk("wait_low", 64'(hreadyout), 64'd0);
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("rst_async_rdy", 64'(hreadyout), 64'd1);
    chk("rst_async_resp", 64'(hresp), 64'd0);
    @(posedge clk); #1;
    rst_n = 1; mon_en = 1;
    q_x(0, 32'h20, 3'd3, 64'h0, 8'h00, 2'b10);
    run_xfers();
    for (int i = 0; i < 150; i++) xq.push_back(rnd_xfer());
    run_xfers();

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL exp_leftover: %0d expectations never completed", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
